// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response bus between fetch and imem.
// master: req/addr out, gnt/rvalid/rdata in; slave: the reverse.
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (
    output req, addr,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Fetch stage: PC, imem requests, redirect/flush, 1-entry skid.
// Ports: clk, rst, stall/redirect in; imem bus; pc/instr/valid/flush out.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0033
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  if_fetch_unit_if.master    imem,
  output logic [31:0]        pc_o,
  output logic [31:0]        instr_o,
  output logic               valid_o,
  output logic               flush_o
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] fetch_pc;
  logic [31:0] req_pc;
  logic        skid_valid;
  logic [31:0] skid_pc;
  logic [31:0] skid_instr;
  logic        req;
  logic        fire;
  logic        rsp;
  logic        slot_free;

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    unique case (state_q)
      S_REQ: begin
        req = !skid_valid;
        // A grant coinciding with a redirect is for a stale address.
        if (req && imem.gnt)
          state_d = redirect_i ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem.rvalid)
          state_d = S_REQ;
        else if (redirect_i)
          state_d = S_DROP;
      end
      S_DROP: begin
        // Response retires the stale request; nothing else is outstanding.
        if (imem.rvalid)
          state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
    if (rst)
      req = 1'b0;
  end

  assign fire      = req && imem.gnt;
  assign rsp       = (state_q == S_WAIT) && imem.rvalid && !redirect_i;
  assign slot_free = !valid_o || !stall_i;

  assign imem.req  = req;
  assign imem.addr = fetch_pc;
  assign flush_o   = redirect_i && !rst;

  always_ff @(posedge clk) begin
    if (rst)
      state_q <= S_REQ;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc   <= RESET_PC;
      req_pc     <= RESET_PC;
      skid_valid <= 1'b0;
      skid_pc    <= 32'h0;
      skid_instr <= NOP;
      valid_o    <= 1'b0;
      pc_o       <= 32'h0;
      instr_o    <= NOP;
    end else begin
      if (redirect_i)
        fetch_pc <= {redirect_pc_i[31:2], 2'b00};
      else if (fire)
        fetch_pc <= fetch_pc + 32'd4;

      if (fire)
        req_pc <= fetch_pc;

      if (redirect_i) begin
        valid_o    <= 1'b0;
        instr_o    <= NOP;
        skid_valid <= 1'b0;
      end else if (slot_free) begin
        unique case (1'b1)
          skid_valid: begin
            // Older skid entry goes first; a new response backfills it.
            pc_o       <= skid_pc;
            instr_o    <= skid_instr;
            valid_o    <= 1'b1;
            skid_valid <= rsp;
            if (rsp) begin
              skid_pc    <= req_pc;
              skid_instr <= imem.rdata;
            end
          end
          rsp: begin
            pc_o    <= req_pc;
            instr_o <= imem.rdata;
            valid_o <= 1'b1;
          end
          default: begin
            valid_o <= 1'b0;
            instr_o <= NOP;
          end
        endcase
      end else if (rsp) begin
        skid_valid <= 1'b1;
        skid_pc    <= req_pc;
        skid_instr <= imem.rdata;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit with a small imem model.
// Memory returns addr^0xA5A50000 after a settable latency.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redir;
  logic [31:0] rpc;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        valid;
  logic        flush;
  logic        noise;
  logic [1:0]  lat;

  logic        mem_pend;
  logic [1:0]  mem_cnt;
  logic [31:0] mem_addr;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] NOP = 32'h0000_0033;
  localparam logic [31:0] K   = 32'hA5A5_0000;

  if_fetch_unit_if bus ();

  if_fetch_unit dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .redirect_i    (redir),
    .redirect_pc_i (rpc),
    .imem          (bus.master),
    .pc_o          (pc),
    .instr_o       (instr),
    .valid_o       (valid),
    .flush_o       (flush)
  );

  always #5 clk = ~clk;

  assign bus.gnt    = bus.req | noise;
  assign bus.rvalid = (mem_pend && mem_cnt == 2'd0) | noise;
  assign bus.rdata  = mem_addr ^ K;

  always @(posedge clk) begin
    if (rst) begin
      mem_pend <= 1'b0;
      mem_cnt  <= 2'd0;
      mem_addr <= 32'h0;
    end else begin
      if (bus.rvalid)
        mem_pend <= 1'b0;
      else if (mem_pend)
        mem_cnt <= mem_cnt - 2'd1;
      if (bus.req && bus.gnt) begin
        mem_pend <= 1'b1;
        mem_cnt  <= lat;
        mem_addr <= bus.addr;
      end
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic out(input string tag,
                     input logic v,
                     input logic [31:0] p,
                     input logic [31:0] i);
    chk({tag, "_valid"}, {31'b0, valid}, {31'b0, v});
    if (v) begin
      chk({tag, "_pc"}, pc, p);
      chk({tag, "_instr"}, instr, i);
    end
  endtask

  task automatic rq(input string tag,
                    input logic r,
                    input logic [31:0] a);
    chk({tag, "_req"}, {31'b0, bus.req}, {31'b0, r});
    if (r)
      chk({tag, "_addr"}, bus.addr, a);
  endtask

  initial begin
    rst   = 1'b1;
    stall = 1'b0;
    redir = 1'b0;
    rpc   = 32'h0;
    noise = 1'b0;
    lat   = 2'd0;

    step();
    noise = 1'b1;
    redir = 1'b1;
    #1;
    rq("rst0", 1'b0, 32'h0);
    chk("rst0_flush", {31'b0, flush}, 32'h0);
    chk("rst0_valid", {31'b0, valid}, 32'h0);
    chk("rst0_instr", instr, NOP);
    chk("rst0_pc", pc, 32'h0);
    step();
    noise = 1'b0;
    #1;
    rq("rst1", 1'b0, 32'h0);
    chk("rst1_flush", {31'b0, flush}, 32'h0);
    chk("rst1_instr", instr, NOP);

    // T0
    step();
    rst   = 1'b0;
    redir = 1'b0;
    #1;
    rq("t0", 1'b1, 32'h0);
    step(); #1; out("t1", 1'b0, 0, 0);
    step(); #1; out("t2", 1'b1, 32'h0, K);
    rq("t2", 1'b1, 32'h4);
    step(); #1; out("t3", 1'b0, 0, 0);
    step(); #1; out("t4", 1'b1, 32'h4, K ^ 32'h4);
    rq("t4", 1'b1, 32'h8);
    stall = 1'b1;
    step(); #1; out("t5", 1'b1, 32'h4, K ^ 32'h4);
    step(); #1; out("t6", 1'b1, 32'h4, K ^ 32'h4);
    rq("t6", 1'b0, 0);
    step(); #1; out("t7", 1'b1, 32'h4, K ^ 32'h4);
    rq("t7", 1'b0, 0);
    stall = 1'b0;
    step(); #1; out("t8", 1'b1, 32'h8, K ^ 32'h8);
    rq("t8", 1'b1, 32'hC);
    lat = 2'd2;

    // redirect while waiting on a slow response
    step();
    redir = 1'b1;
    rpc   = 32'h100;
    #1;
    out("t9", 1'b0, 0, 0);
    chk("t9_flush", {31'b0, flush}, 32'h1);
    rq("t9", 1'b0, 0);
    step();
    redir = 1'b0;
    lat   = 2'd0;
    #1;
    chk("t10_flush", {31'b0, flush}, 32'h0);
    out("t10", 1'b0, 0, 0);
    rq("t10", 1'b0, 0);
    step(); #1; out("t11", 1'b0, 0, 0);
    rq("t11", 1'b0, 0);
    step(); #1; out("t12", 1'b0, 0, 0);
    rq("t12", 1'b1, 32'h100);
    step(); #1; out("t13", 1'b0, 0, 0);
    step(); #1; out("t14", 1'b1, 32'h100, K ^ 32'h100);
    rq("t14", 1'b1, 32'h104);

    // redirect coincident with grant, unaligned target
    redir = 1'b1;
    rpc   = 32'h203;
    #1;
    chk("t14_flush", {31'b0, flush}, 32'h1);
    step();
    redir = 1'b0;
    #1;
    out("t15", 1'b0, 0, 0);
    rq("t15", 1'b0, 0);
    step(); #1; out("t16", 1'b0, 0, 0);
    rq("t16", 1'b1, 32'h200);
    step(); #1; out("t17", 1'b0, 0, 0);
    step(); #1; out("t18", 1'b1, 32'h200, K ^ 32'h200);
    rq("t18", 1'b1, 32'h204);

    // wrap past the top of the address space
    redir = 1'b1;
    rpc   = 32'hFFFF_FFFC;
    step();
    redir = 1'b0;
    #1;
    out("t19", 1'b0, 0, 0);
    step(); #1; rq("t20", 1'b1, 32'hFFFF_FFFC);
    step(); #1; out("t21", 1'b0, 0, 0);
    rq("t21", 1'b0, 0);
    step(); #1; out("t22", 1'b1, 32'hFFFF_FFFC, 32'h5A5A_FFFC);
    rq("t22", 1'b1, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
